// File: rtl/decoder_scan_n.sv
// ---------------------------------------------------------------------------
// decoder_scan_n
// Registered N-to-2^N one-hot decoder with an autonomous LED-matrix scan mode.
//   direct mode (mode=0): out <= onehot(sel), index <= sel, every cycle.
//   scan mode   (mode=1): walks every line, holding each for dwell+1 cycles,
//                         followed by BLANK_CYCLES all-zero cycles; the first
//                         cycle of line 0 raises frame_start.
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   ena          block enable (0 forces IDLE, out=0, index held)
//   mode         0 = direct decode, 1 = scan
//   sel[N]       line select (direct mode only)
//   dwell[DW]    scan hold time minus one, sampled at each line start
//   out[2^N]     one-hot line drive or all zeros (registered)
//   index[N]     line currently driven (registered)
//   frame_start  one-cycle pulse on the first cycle of line 0 (registered)
// ---------------------------------------------------------------------------
module decoder_scan_n #(
    parameter int unsigned N            = 3,
    parameter int unsigned DWELL_W      = 8,
    parameter int unsigned BLANK_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic                 mode,
    input  logic [N-1:0]         sel,
    input  logic [DWELL_W-1:0]   dwell,
    output logic [(1<<N)-1:0]    out,
    output logic [N-1:0]         index,
    output logic                 frame_start
);

    localparam int unsigned LINES   = 1 << N;
    localparam int unsigned BLANK_W = 8;
    localparam bit          HAS_BLANK = (BLANK_CYCLES != 0);
    // Blank counter counts down to zero, so it is loaded with length-1.
    localparam logic [BLANK_W-1:0] BLANK_LOAD =
        BLANK_W'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIRECT = 2'd1,
        S_ACTIVE = 2'd2,
        S_BLANK  = 2'd3
    } state_t;

    // One-hot expansion of a line number.
    function automatic logic [LINES-1:0] onehot(input logic [N-1:0] line);
        logic [LINES-1:0] v;
        v       = '0;
        v[line] = 1'b1;
        return v;
    endfunction

    state_t               r_state;
    logic [LINES-1:0]     r_out;
    logic [N-1:0]         r_index;
    logic                 r_frame_start;
    logic [DWELL_W-1:0]   r_dwell_cnt;
    logic [BLANK_W-1:0]   r_blank_cnt;

    state_t               w_state;
    logic [LINES-1:0]     w_out;
    logic [N-1:0]         w_index;
    logic                 w_frame_start;
    logic [DWELL_W-1:0]   w_dwell_cnt;
    logic [BLANK_W-1:0]   w_blank_cnt;
    logic [N-1:0]         w_next_index;
    logic                 w_start;
    logic                 w_advance;

    // Wrap from 2^N-1 to 0 falls out of the N-bit addition.
    assign w_next_index = r_index + N'(1);

    // Next-state and next-output logic.
    always_comb begin
        w_state       = r_state;
        w_out         = '0;
        w_index       = r_index;
        w_frame_start = 1'b0;
        w_dwell_cnt   = r_dwell_cnt;
        w_blank_cnt   = r_blank_cnt;
        w_start       = 1'b0;
        w_advance     = 1'b0;

        if (!ena) begin
            // Enable low wins over any mode change.
            w_state = S_IDLE;
        end else if (!mode) begin
            w_state = S_DIRECT;
            w_out   = onehot(sel);
            w_index = sel;
        end else begin
            case (r_state)
                S_ACTIVE: begin
                    if (r_dwell_cnt == '0) begin
                        if (HAS_BLANK) begin
                            w_state     = S_BLANK;
                            w_blank_cnt = BLANK_LOAD;
                        end else begin
                            w_advance = 1'b1;
                        end
                    end else begin
                        w_dwell_cnt = r_dwell_cnt - DWELL_W'(1);
                        w_out       = onehot(r_index);
                    end
                end
                S_BLANK: begin
                    if (r_blank_cnt == '0) begin
                        w_advance = 1'b1;
                    end else begin
                        w_blank_cnt = r_blank_cnt - BLANK_W'(1);
                    end
                end
                // Entry from IDLE or DIRECT always restarts the frame.
                default: w_start = 1'b1;
            endcase
        end

        if (w_start) begin
            w_state       = S_ACTIVE;
            w_index       = '0;
            w_out         = onehot(N'(0));
            w_dwell_cnt   = dwell;
            w_frame_start = 1'b1;
        end

        // Dwell is sampled only here, so a mid-line change hits the next line.
        if (w_advance) begin
            w_state       = S_ACTIVE;
            w_index       = w_next_index;
            w_out         = onehot(w_next_index);
            w_dwell_cnt   = dwell;
            w_frame_start = (w_next_index == '0);
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_out         <= '0;
            r_index       <= '0;
            r_frame_start <= 1'b0;
            r_dwell_cnt   <= '0;
            r_blank_cnt   <= '0;
        end else begin
            r_state       <= w_state;
            r_out         <= w_out;
            r_index       <= w_index;
            r_frame_start <= w_frame_start;
            r_dwell_cnt   <= w_dwell_cnt;
            r_blank_cnt   <= w_blank_cnt;
        end
    end

    assign out         = r_out;
    assign index       = r_index;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_decoder_scan_n.sv
// ---------------------------------------------------------------------------
// tb_decoder_scan_n
// Two decoder_scan_n instances (N=3, BLANK_CYCLES=1 and 0) share all inputs.
// A line/phase reference model predicts out, index and frame_start per cycle.
// ---------------------------------------------------------------------------
module tb_decoder_scan_n;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ena = 1'b0;
    logic       mode = 1'b0;
    logic [2:0] sel = 3'd0;
    logic [7:0] dwell = 8'd0;

    logic [7:0] dut_out [2];
    logic [2:0] dut_idx [2];
    logic       dut_fs  [2];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    decoder_scan_n #(.N(3), .DWELL_W(8), .BLANK_CYCLES(1)) u_dut_b1 (
        .clk(clk), .rst(rst), .ena(ena), .mode(mode), .sel(sel), .dwell(dwell),
        .out(dut_out[0]), .index(dut_idx[0]), .frame_start(dut_fs[0])
    );

    decoder_scan_n #(.N(3), .DWELL_W(8), .BLANK_CYCLES(0)) u_dut_b0 (
        .clk(clk), .rst(rst), .ena(ena), .mode(mode), .sel(sel), .dwell(dwell),
        .out(dut_out[1]), .index(dut_idx[1]), .frame_start(dut_fs[1])
    );

    // Reference model: scan position kept as (line, phase within line period).
    int unsigned blank_of [2] = '{1, 0};
    bit          m_scan  [2];
    int unsigned m_line  [2];
    int unsigned m_phase [2];
    int unsigned m_len   [2];
    logic [7:0]  m_out   [2];
    logic [2:0]  m_idx   [2];
    logic        m_fs    [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_scan[k] = 1'b0; m_line[k] = 0; m_phase[k] = 0; m_len[k] = 1;
            m_out[k] = 8'h00; m_idx[k] = 3'd0; m_fs[k] = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                m_scan[k] = 1'b0; m_out[k] = 8'h00; m_idx[k] = 3'd0; m_fs[k] = 1'b0;
            end else if (!ena) begin
                m_scan[k] = 1'b0; m_out[k] = 8'h00; m_fs[k] = 1'b0;
            end else if (!mode) begin
                m_scan[k] = 1'b0; m_out[k] = 8'(1 << sel); m_idx[k] = sel; m_fs[k] = 1'b0;
            end else begin
                if (!m_scan[k]) begin
                    m_scan[k] = 1'b1; m_line[k] = 0; m_phase[k] = 0;
                    m_len[k] = int'(dwell) + 1;
                end else begin
                    m_phase[k]++;
                    if (m_phase[k] == m_len[k] + blank_of[k]) begin
                        m_line[k]  = (m_line[k] + 1) % 8;
                        m_phase[k] = 0;
                        m_len[k]   = int'(dwell) + 1;
                    end
                end
                m_out[k] = (m_phase[k] < m_len[k]) ? 8'(1 << m_line[k]) : 8'h00;
                m_idx[k] = 3'(m_line[k]);
                m_fs[k]  = (m_phase[k] == 0) && (m_line[k] == 0);
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s_b%0d_out", tag, blank_of[k]), 32'(dut_out[k]), 32'(m_out[k]));
            check($sformatf("%s_b%0d_idx", tag, blank_of[k]), 32'(dut_idx[k]), 32'(m_idx[k]));
            check($sformatf("%s_b%0d_fs", tag, blank_of[k]), 32'(dut_fs[k]), 32'(m_fs[k]));
            check($sformatf("%s_b%0d_onehot0", tag, blank_of[k]),
                  32'($countones(dut_out[k]) <= 1), 32'd1);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    initial begin
        int fs_cnt [2];
        int zero_cnt [2];
        bit reached;

        model_reset();

        // Reset held low for 3 cycles with ena low.
        repeat (3) @(posedge clk);
        #1;
        check_all("reset_hold");
        rst = 1'b1;
        step("reset_release");

        // Direct decode of every select value.
        ena = 1'b1; mode = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sel = 3'(i);
            step("direct");
            check("direct_const_out", 32'(dut_out[0]), 32'd1 << i);
        end
        ena = 1'b0; sel = 3'd5;
        step("direct_disable");
        check("direct_disable_out", 32'(dut_out[0]), 32'd0);

        // Scan dwell=2: two frames of the blanking instance, ~2.7 of the other.
        ena = 1'b1; mode = 1'b1; dwell = 8'd2;
        fs_cnt = '{0, 0}; zero_cnt = '{0, 0};
        for (int c = 0; c < 64; c++) begin
            step("scan_d2");
            for (int k = 0; k < 2; k++) begin
                if (dut_fs[k]) fs_cnt[k]++;
                if (c < 32 && dut_out[k] == 8'h00) zero_cnt[k]++;
            end
        end
        check("scan_d2_fs_b1", 32'(fs_cnt[0]), 32'd2);
        check("scan_d2_fs_b0", 32'(fs_cnt[1]), 32'd3);
        check("scan_d2_zero_b1", 32'(zero_cnt[0]), 32'd8);
        check("scan_d2_zero_b0", 32'(zero_cnt[1]), 32'd0);

        // Scan dwell=0: no-blank instance steps every cycle.
        ena = 1'b0;
        step("idle_d0");
        ena = 1'b1; dwell = 8'd0;
        fs_cnt = '{0, 0}; zero_cnt = '{0, 0};
        for (int c = 0; c < 16; c++) begin
            step("scan_d0");
            check("scan_d0_walk", 32'(dut_out[1]), 32'd1 << (c % 8));
            if (dut_fs[1]) fs_cnt[1]++;
            if (dut_out[1] == 8'h00) zero_cnt[1]++;
        end
        check("scan_d0_fs_b0", 32'(fs_cnt[1]), 32'd2);
        check("scan_d0_zero_b0", 32'(zero_cnt[1]), 32'd0);

        // Dwell change during line 2 only affects line 3.
        ena = 1'b0;
        step("idle_dw");
        ena = 1'b1; dwell = 8'd3;
        reached = 1'b0;
        for (int c = 0; c < 100 && !reached; c++) begin
            step("dw_wait");
            if (m_scan[0] && m_line[0] == 2 && m_phase[0] == 0) reached = 1'b1;
        end
        check("dw_wait_reached", 32'(reached), 32'd1);
        dwell = 8'd0;
        step("dw_l2"); step("dw_l2");
        step("dw_l2");
        check("dw_l2_last", 32'(dut_out[0]), 32'h04);
        step("dw_blank2");
        check("dw_blank2_out", 32'(dut_out[0]), 32'h00);
        step("dw_l3");
        check("dw_l3_out", 32'(dut_out[0]), 32'h08);
        step("dw_blank3");
        check("dw_blank3_out", 32'(dut_out[0]), 32'h00);
        step("dw_l4");
        check("dw_l4_out", 32'(dut_out[0]), 32'h10);

        // Mode switching at scan index 5.
        reached = 1'b0;
        for (int c = 0; c < 100 && !reached; c++) begin
            step("ms_wait");
            if (dut_idx[0] == 3'd5) reached = 1'b1;
        end
        check("ms_wait_reached", 32'(reached), 32'd1);
        mode = 1'b0; sel = 3'd1;
        step("ms_to_direct");
        check("ms_to_direct_out", 32'(dut_out[0]), 32'h02);
        mode = 1'b1;
        step("ms_to_scan");
        check("ms_to_scan_out", 32'(dut_out[0]), 32'h01);
        check("ms_to_scan_fs", 32'(dut_fs[0]), 32'd1);
        ena = 1'b0; mode = 1'b0;
        step("ms_ena_wins");
        check("ms_ena_wins_b1", 32'(dut_out[0]), 32'h00);
        check("ms_ena_wins_b0", 32'(dut_out[1]), 32'h00);

        // Asynchronous reset mid-scan.
        ena = 1'b1; mode = 1'b1; dwell = 8'd1;
        repeat (5) step("pre_async");
        rst = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        step("async_rst_hold");
        rst = 1'b1; ena = 1'b0;
        step("async_rst_release");

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            ena = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 39) == 0) mode = ~mode;
            sel = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) dwell = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b0;
                #1;
                model_reset();
                check_all("rand_async_rst");
                rst = 1'b1;
            end
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/decoder_scan_n.md
Name: decoder_scan_n

Overview:
- Parametrised, registered N-to-2^N one-hot decoder; next generation of the game-of-life 3-to-8 decoder.
- Adds an autonomous scan mode for driving LED-matrix rows/columns: steps through every output line with a programmable dwell time and a blanking gap between lines, and flags each frame start.
- A direct mode keeps the plain decoder function, now with a registered output.
- Sits between the game-of-life board logic and the display driver.

Parameters:
- N, 3, select width; output width is 2^N.
- DWELL_W, 8, width of the dwell input.
- BLANK_CYCLES, 1, all-zero cycles inserted between scan lines; 0 means no gap. Range 0..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset. Asserts immediately; deassertion is synchronous to clk.
- ena  input  1  block enable.
- mode  input  1  0 = direct decode, 1 = scan.
- sel  input  N  line select, used in direct mode only.
- dwell  input  DWELL_W  scan mode: each line is held for dwell+1 cycles.
- out  output  2^N  one-hot line drive, or all zeros.
- index  output  N  line currently driven (direct: registered sel; scan: scan pointer).
- frame_start  output  1  one-cycle pulse.

Behaviour:
- Reset (rst low): out=0, index=0, frame_start=0, dwell counter=0, blank counter=0, state=IDLE. Applies asynchronously, mid-operation included.
- All outputs are registered. Inputs are sampled on a rising edge and take effect in the outputs after that edge (latency 1).
- States: IDLE, DIRECT, ACTIVE, BLANK.
- IDLE:
  - out=0, frame_start=0, index holds.
  - ena=1 & mode=0 -> DIRECT.
  - ena=1 & mode=1 -> ACTIVE with index=0, dwell counter loaded from dwell, frame_start=1.
- DIRECT: every cycle out<=onehot(sel), index<=sel, frame_start=0.
- ACTIVE:
  - out=onehot(index).
  - Dwell counter decrements each cycle.
  - When it is 0: go to BLANK if BLANK_CYCLES>0, otherwise advance directly.
- BLANK: out=0 for exactly BLANK_CYCLES cycles, then advance.
- Advance:
  - index<=(index+1) mod 2^N; wrap from 2^N-1 to 0 is the only overflow.
  - Re-enter ACTIVE and reload the dwell counter from the current dwell input. Dwell is sampled only at ACTIVE entry, so a mid-line change affects the next line only.
  - frame_start=1 in the first ACTIVE cycle of index 0 only.
- Line period in scan mode = dwell+1+BLANK_CYCLES cycles; frame period = 2^N times that.
- ena=0 in any state: next cycle out=0, frame_start=0, state=IDLE, index holds. Re-enable in scan restarts at index 0.
- Mode change with ena=1:
  - 1->0: DIRECT on the next cycle, decoding sel.
  - 0->1: ACTIVE at index 0 with frame_start=1, regardless of the previous sel.
- Simultaneous ena falling and mode change: ena wins (IDLE).
- Invariant: out is always one-hot or all zeros; never more than one bit set.

Test Plan:
- N=3, rst low for 3 cycles, then high with ena=0 -> out=8'h00, index=0, frame_start=0. Assert rst low mid-scan -> out=0 immediately, without waiting for a clock edge.
- Direct: ena=1, mode=0, sel=0..7 one per cycle -> out one cycle later is 8'h01,02,04,...,80 and index=sel. Then ena=0 with sel=5 -> out=8'h00 next cycle.
- Scan: dwell=2, BLANK_CYCLES=1 -> each line one-hot for 3 cycles, then 1 zero cycle. Sequence 01,01,01,00,02,02,02,00,...,80,80,80,00, then 01 with frame_start=1. Frame = 32 cycles; frame_start fires exactly once per frame.
- Scan: dwell=0, BLANK_CYCLES=0 -> out walks 01,02,...,80,01 one step per cycle. frame_start fires every 8 cycles; no all-zero cycles appear.
- Dwell change mid-line: dwell=3, then set dwell=0 during line 2 -> line 2 still lasts 4 cycles and line 3 lasts 1 cycle.
- Mode/enable switching: in scan at index 5, switch to mode=0 with sel=1 -> out=8'h02 next cycle. Switch back to mode=1 -> out=8'h01 with frame_start=1. Drop ena together with a mode change -> out=0.
